// File: rtl/led_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_pkg
// Summary  : Shared types and constants for the LED pattern engine: the mode
//            encoding, the PWM counter width and the mode-advance helper.
// Revision : 1.0 - initial release
// ============================================================================
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam int PWM_W = 4;

    // Press order: OFF -> BLINK -> CHASE -> BREATHE -> OFF
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_OFF:   nxt = MODE_BLINK;
            MODE_BLINK: nxt = MODE_CHASE;
            MODE_CHASE: nxt = MODE_BREATHE;
            default:    nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_debounce.sv
`default_nettype none
// ============================================================================
// Module   : led_debounce
// Summary  : Two-flop synchroniser, tick-based debouncer and press pulse
//            generator for the mode push-button.
// Revision : 1.0 - initial release
// ============================================================================
module led_debounce
    import led_blink_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic FAB_CLK,
    input  logic RESET,
    input  logic TICK,
    input  logic i_btn,
    output logic o_press
);

    localparam int c_DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_TICKS - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic              r_press;
    logic [c_DB_W-1:0] r_cnt;

    // Bring the asynchronous button into the FAB_CLK domain
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it differs on consecutive ticks; any
    // cycle where it matches the accepted level restarts the count
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (TICK) begin
                if (r_cnt == c_DB_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2;   // only the 0->1 change is an event
                end else begin
                    r_cnt <= r_cnt + c_DB_W'(1);
                end
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_ctrl
// Summary  : LED pattern engine. Divides FAB_CLK to a slow tick, debounces the
//            mode button and drives OFF / BLINK / CHASE / BREATHE patterns.
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int TICK_HZ         = 1000,
    parameter int NUM_LEDS        = 8,
    parameter int DEBOUNCE_TICKS  = 20,
    parameter int BASE_STEP_TICKS = 512
) (
    input  logic                FAB_CLK,
    input  logic                RESET,
    input  logic                BTN_MODE,
    input  logic [1:0]          RATE_SEL,
    output logic [NUM_LEDS-1:0] LED,
    output logic [1:0]          MODE,
    output logic                TICK
);

    localparam int c_DIV    = CLK_HZ / TICK_HZ;
    localparam int c_PRE_W  = $clog2(c_DIV);
    localparam int c_STEP_W = $clog2(BASE_STEP_TICKS);
    localparam int c_PER_W  = c_STEP_W + 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST = c_PRE_W'(c_DIV - 1);
    localparam logic [c_PRE_W-1:0]  c_PRE_ARM  = c_PRE_W'(c_DIV - 2);
    localparam logic [c_PER_W-1:0]  c_BASE     = c_PER_W'(BASE_STEP_TICKS);
    localparam logic [PWM_W-1:0]    c_DUTY_MAX = '1;
    localparam logic [NUM_LEDS-1:0] c_LED_ONE  = NUM_LEDS'(1);

    logic [c_PRE_W-1:0]  r_pre_cnt;
    logic                r_tick;
    logic [PWM_W-1:0]    r_pwm;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic [1:0]          r_rate;
    logic                r_step;
    logic [PWM_W-1:0]    r_duty;
    logic                r_dir_up;
    mode_e               r_mode;
    logic [NUM_LEDS-1:0] r_led;

    logic                w_press;
    mode_e               w_mode_nxt;
    logic [c_PER_W-1:0]  w_period_m1;
    logic                w_pwm_on;

    assign w_mode_nxt  = next_mode(r_mode);
    assign w_period_m1 = (c_BASE >> r_rate) - c_PER_W'(1);
    assign w_pwm_on    = (r_pwm < r_duty);

    led_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
        .FAB_CLK (FAB_CLK),
        .RESET   (RESET),
        .TICK    (r_tick),
        .i_btn   (BTN_MODE),
        .o_press (w_press)
    );

    // Prescaler; the tick flop is armed one count early so it is high exactly
    // while the counter sits at its terminal value. PWM advances on ticks.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
            r_pwm     <= '0;
        end else begin
            r_pre_cnt <= (r_pre_cnt == c_PRE_LAST) ? '0 : r_pre_cnt + c_PRE_W'(1);
            r_tick    <= (r_pre_cnt == c_PRE_ARM);
            if (r_tick) begin
                r_pwm <= r_pwm + PWM_W'(1);
            end
        end
    end

    // Mode FSM, step timer and pattern register; a press reinitialises
    // everything and swallows any step or tick landing in the same cycle
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            r_mode     <= MODE_OFF;
            r_led      <= '0;
            r_step_cnt <= '0;
            r_rate     <= 2'd0;
            r_step     <= 1'b0;
            r_duty     <= '0;
            r_dir_up   <= 1'b1;
        end else begin
            r_step <= 1'b0;
            if (w_press) begin
                r_mode     <= w_mode_nxt;
                r_step_cnt <= '0;
                r_rate     <= RATE_SEL;
                r_duty     <= '0;
                r_dir_up   <= 1'b1;
                case (w_mode_nxt)
                    MODE_BLINK: r_led <= '1;
                    MODE_CHASE: r_led <= c_LED_ONE;
                    default:    r_led <= '0;
                endcase
            end else begin
                if (r_tick) begin
                    if ({1'b0, r_step_cnt} == w_period_m1) begin
                        r_step     <= 1'b1;
                        r_step_cnt <= '0;
                        r_rate     <= RATE_SEL;   // new rate only at a period boundary
                    end else begin
                        r_step_cnt <= r_step_cnt + c_STEP_W'(1);
                    end
                end
                case (r_mode)
                    MODE_OFF: begin
                        r_led <= '0;
                    end
                    MODE_BLINK: begin
                        if (r_step) r_led <= ~r_led;
                    end
                    MODE_CHASE: begin
                        if (r_step) r_led <= {r_led[NUM_LEDS-2:0], r_led[NUM_LEDS-1]};
                    end
                    default: begin
                        r_led <= {NUM_LEDS{w_pwm_on}};
                        if (r_step) begin
                            if (r_dir_up) begin
                                if (r_duty == c_DUTY_MAX) begin
                                    r_duty   <= r_duty - PWM_W'(1);
                                    r_dir_up <= 1'b0;
                                end else begin
                                    r_duty <= r_duty + PWM_W'(1);
                                end
                            end else begin
                                if (r_duty == '0) begin
                                    r_duty   <= r_duty + PWM_W'(1);
                                    r_dir_up <= 1'b1;
                                end else begin
                                    r_duty <= r_duty - PWM_W'(1);
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign LED  = r_led;
    assign MODE = r_mode;
    assign TICK = r_tick;

endmodule
`default_nettype wire
